mips_imem_sequencer: RTL and testbench
======================================

# mips_imem_sequencer

Parametrised, synthesizable instruction-memory sequencer that replaces the behavioural instruction source in front of the MIPS core. A program is streamed in over a valid/ready load port. The block then serves PC-indexed instructions to the core with one-cycle registered latency. Out-of-range fetches are guarded, and a cycle watchdog halts a runaway program.

## Interface
Parameters:
- `PC_WIDTH`, default 32: byte-address width of `pc`.
- `INSTR_WIDTH`, default 32: instruction word width.
- `DEPTH`, default 256: words of storage; power of two, minimum 4.
- `WDOG_CYCLES`, default 100000: RUN cycles before watchdog halt; minimum 1.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load_valid`, input, 1: load word offered.
- `load_ready`, output, 1: block accepts load word.
- `load_data`, input, INSTR_WIDTH: instruction word to store.
- `load_last`, input, 1: final word of program.
- `pc`, input, PC_WIDTH: core fetch address (byte).
- `instr`, output, INSTR_WIDTH: fetched instruction, registered.
- `instr_valid`, output, 1: `instr` is a real program word.
- `running`, output, 1: state is RUN.
- `halted`, output, 1: state is HALT.
- `oob_err`, output, 1: sticky; fetch beyond program length or misaligned.
- `wdog_expired`, output, 1: sticky; watchdog fired.

## Operation
- States: IDLE, LOAD, RUN, HALT.
- Reset: state IDLE, write pointer 0, `prog_len` 0, watchdog counter 0. All outputs read 0, `instr` reads NOP (0x0000_0000). RAM contents are not cleared.
- IDLE:
  - `load_ready`=1.
  - An accepted word (`load_valid`&`load_ready`) is written at pointer 0 and the state moves to LOAD.
  - If that word has `load_last`=1, the state goes directly to RUN.
- LOAD:
  - `load_ready`=1. Each accepted word is written at the pointer, and the pointer increments.
  - On acceptance with `load_last`=1, or on acceptance at pointer DEPTH-1: `prog_len` = pointer+1 and the state moves to RUN.
  - Words after a forced DEPTH end are not accepted until HALT.
- RUN:
  - `load_ready`=0.
  - Fetch index = `pc[$clog2(DEPTH)+1:2]`.
  - If `pc[1:0]`≠0, or the index ≥ `prog_len`, or any `pc` bit above the index is nonzero: `instr` = NOP, `instr_valid`=0, `oob_err` set.
  - Otherwise `instr` = RAM[index] and `instr_valid`=1.
- HALT:
  - `instr` = NOP, `instr_valid`=0, `load_ready`=1.
  - An accepted word restarts loading at pointer 0, clears both sticky flags and the watchdog, and moves to LOAD (or RUN if `load_last`).
- Outside RUN, `instr` = NOP and `instr_valid`=0.
- Reset mid-LOAD discards the partial program (`prog_len` 0).

## Timing
- Load acceptance takes effect on the same edge as the handshake. A write at pointer p is readable from the first RUN cycle.
- Fetch latency is exactly 1 cycle: `pc` sampled at edge n, `instr` valid after edge n. `oob_err` asserts on the same edge.
- `running` asserts the cycle after `load_last` is accepted. The first fetch is honoured in that first RUN cycle.
- `load_valid` held with `load_ready`=0 is ignored, with no side effects.

## Configuration
- `IMEM_WATCHDOG_EN` defined:
  - A 32-bit counter increments each RUN cycle.
  - When it reaches `WDOG_CYCLES`, the state moves to HALT on the next edge and `wdog_expired` is set.
  - The counter clears on leaving RUN.
- `IMEM_WATCHDOG_EN` undefined:
  - No counter; RUN persists until reset or never ends.
  - `wdog_expired` is tied to 0.
  - HALT is unreachable.

## Structure
- `mips_pkg` holds:
  - `imem_state_e` (IDLE, LOAD, RUN, HALT).
  - `MIPS_NOP` constant (32'h0).
- Sub-module `mips_imem_ram`: single-port write, registered read, `DEPTH`×`INSTR_WIDTH`, no reset on the array.
- Top block: FSM, pointers, range checks, watchdog.

## Test plan
- Load 4 words 0x2001_0005…0x2004_0008 with `load_last` on the 4th. Then drive pc=0x0,0x4,0x8,0xC. `instr` returns the same words, one cycle after each pc, with `instr_valid`=1.
- After a 4-word load, drive pc=0x10, then pc=0x6. Both cycles return NOP with `instr_valid`=0, and `oob_err`=1 remains set.
- Stream DEPTH+2 words with no `load_last`. After DEPTH words the block enters RUN and `load_ready`=0. pc=(DEPTH-1)*4 returns the last word.
- Assert `rst` after 2 of 4 load words. State returns to IDLE, `prog_len`=0, and the next accepted word lands at pointer 0.
- With `IMEM_WATCHDOG_EN` defined and `WDOG_CYCLES`=10, load 1 word. `halted`=1 and `wdog_expired`=1 ten RUN cycles later. A new load clears both flags and RUN resumes.
- With `IMEM_WATCHDOG_EN` undefined, run 1000 cycles. `halted` stays 0 and `wdog_expired` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-memory sequencer.
// Holds the sequencer state encoding and the canonical NOP word.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } imem_state_e;

    // sll $0,$0,0: the word the core sees whenever no real instruction is served
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    localparam int WDOG_CNT_WIDTH = 32;

endpackage

// File: rtl/mips_imem_ram.sv
// Instruction storage: one write port, one registered read port, DEPTH x INSTR_WIDTH.
// The array holds no reset so it maps onto plain block RAM.
module mips_imem_ram #(
    parameter int DEPTH       = 256,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_WIDTH-1:0]   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_WIDTH-1:0]   rdata
);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register are deliberately left out of reset;
    // a reset term would stop the storage from mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mips_imem_sequencer.sv
// Instruction-memory sequencer: streamed program load, PC-indexed fetch with range
// guard, optional RUN-cycle watchdog (enabled by defining IMEM_WATCHDOG_EN).
module mips_imem_sequencer
    import mips_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 256,
    parameter int WDOG_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic                   running,
    output logic                   halted,
    output logic                   oob_err,
    output logic                   wdog_expired
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("mips_imem_sequencer: DEPTH must be a power of two and at least 4");
    end
    if (WDOG_CYCLES < 1) begin : g_wdog_chk
        $error("mips_imem_sequencer: WDOG_CYCLES must be at least 1");
    end

    imem_state_e state, state_nxt;

    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            prog_len;
    logic                   valid_q;
    logic                   oob_q;
    logic                   wdog_q;

    logic                   accept;
    logic                   load_done;
    logic                   wdog_fire;
    logic                   fetch_ok;
    logic [AW-1:0]          fetch_idx;
    logic [PC_WIDTH-1:0]    pc_upper;
    logic [AW-1:0]          ram_waddr;
    logic [INSTR_WIDTH-1:0] ram_rdata;

    assign accept    = load_valid && load_ready;
    // A load ends on load_last or when the final storage slot has been written.
    assign load_done = accept && (load_last || (state == LOAD && wr_ptr == AW'(DEPTH - 1)));
    assign ram_waddr = (state == LOAD) ? wr_ptr : '0;

    assign fetch_idx = pc[AW+1:2];
    assign pc_upper  = pc >> (AW + 2);
    assign fetch_ok  = (pc[1:0] == 2'b00) && ({1'b0, fetch_idx} < prog_len) && (pc_upper == '0);

`ifdef IMEM_WATCHDOG_EN
    logic [WDOG_CNT_WIDTH-1:0] wdog_cnt;

    // Fires in the RUN cycle whose closing edge brings the count to WDOG_CYCLES.
    assign wdog_fire = (state == RUN) && (wdog_cnt == WDOG_CNT_WIDTH'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == RUN && !wdog_fire) begin
            wdog_cnt <= wdog_cnt + WDOG_CNT_WIDTH'(1);
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE, HALT: if (accept) state_nxt = load_done ? RUN : LOAD;
            LOAD:       if (load_done) state_nxt = RUN;
            RUN:        if (wdog_fire) state_nxt = HALT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready  = 1'b0;
        running     = 1'b0;
        halted      = 1'b0;
        unique case (state)
            IDLE, LOAD: load_ready = !rst;
            RUN:        running    = 1'b1;
            HALT: begin
                load_ready = !rst;
                halted     = 1'b1;
            end
            default:    load_ready = 1'b0;
        endcase
        instr_valid = valid_q && (state == RUN);
        instr       = instr_valid ? ram_rdata : INSTR_WIDTH'(MIPS_NOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            prog_len <= '0;
            valid_q  <= 1'b0;
            oob_q    <= 1'b0;
            wdog_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (state == LOAD) ? wr_ptr + AW'(1) : AW'(1);
                if (load_done) begin
                    prog_len <= (state == LOAD) ? {1'b0, wr_ptr} + (AW + 1)'(1) : (AW + 1)'(1);
                end else if (state != LOAD) begin
                    prog_len <= '0;
                end
            end
            valid_q <= (state == RUN) && fetch_ok;
            // Restarting from HALT clears the sticky flags before any new fetch.
            if (accept && state == HALT) begin
                oob_q  <= 1'b0;
                wdog_q <= 1'b0;
            end else begin
                if (state == RUN && !fetch_ok) oob_q <= 1'b1;
                if (wdog_fire) wdog_q <= 1'b1;
            end
        end
    end

    assign oob_err      = oob_q;
    assign wdog_expired = wdog_q;

    mips_imem_ram #(
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (ram_waddr),
        .wdata (load_data),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mips_imem_sequencer.sv
// Self-checking bench for mips_imem_sequencer: load, fetch, range guard, forced end,
// reset mid-load, and the watchdog (IMEM_WATCHDOG_EN) or its absence.
module tb_mips_imem_sequencer;

    localparam int DEPTH = 16;
    localparam int WDOG  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        running;
    logic        halted;
    logic        oob_err;
    logic        wdog_expired;

    mips_imem_sequencer #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .DEPTH       (DEPTH),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .running      (running),
        .halted       (halted),
        .oob_err      (oob_err),
        .wdog_expired (wdog_expired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          model_ptr;
    int          model_len;
    logic        model_oob;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        int   idx;
        e.instr = 32'h0;
        e.valid = 1'b0;
        idx = int'(a >> 2);
        if (a[1:0] == 2'b00 && idx < model_len) begin
            e.instr = model_mem[idx];
            e.valid = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_accept(input logic [31:0] data, input logic last);
        model_mem[model_ptr] = data;
        model_ptr++;
        if (last || model_ptr == DEPTH) model_len = model_ptr;
    endfunction

    function automatic void model_clear();
        model_ptr = 0;
        model_len = 0;
        model_oob = 1'b0;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        step();
        model_clear();
        sb_q.delete();
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_oob", 32'(oob_err), 32'd0);
        check("rst_wdog", 32'(wdog_expired), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_load_ready", 32'(load_ready), 32'd1);
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        check($sformatf("load_ready@%0d", model_ptr), 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        model_accept(data, last);
    endtask

    task automatic fetch(input logic [31:0] addr);
        exp_t e;
        pc = addr;
        sb_q.push_back(model_fetch(addr));
        step();
        e = sb_q.pop_front();
        model_oob = model_oob | !e.valid;
        check($sformatf("instr pc=%08h", addr), instr, e.instr);
        check($sformatf("instr_valid pc=%08h", addr), 32'(instr_valid), 32'(e.valid));
        check($sformatf("oob_err pc=%08h", addr), 32'(oob_err), 32'(model_oob));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   accepted;
        logic seen_halt;
        logic seen_wdog;
        pc        = 32'h0;
        load_data = 32'h0;
        do_reset();

        // Four-word program, then in-range fetches.
        load_word(32'h2001_0005, 1'b0);
        load_word(32'h2002_0006, 1'b0);
        load_word(32'h2003_0007, 1'b0);
        check("running_before_last", 32'(running), 32'd0);
        load_word(32'h2004_0008, 1'b1);
        check("running_after_last", 32'(running), 32'd1);
        check("run_load_ready", 32'(load_ready), 32'd0);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));

        // Out-of-range, misaligned and upper-bit fetches; flag stays sticky.
        fetch(32'h0000_0010);
        fetch(32'h0000_0006);
        fetch(32'h8000_0000);
        fetch(32'h0000_0004);

        // Forced end at DEPTH words; the two extra words are ignored.
        do_reset();
        accepted   = 0;
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_data = 32'hA500_0000 | 32'(i);
            if (load_ready) begin
                model_accept(load_data, 1'b0);
                accepted++;
            end
            step();
        end
        load_valid = 1'b0;
        check("forced_accepted", 32'(accepted), 32'(DEPTH));
        check("forced_running", 32'(running), 32'd1);
        check("forced_load_ready", 32'(load_ready), 32'd0);
        fetch(32'((DEPTH - 1) * 4));
        fetch(32'h0);
        fetch(32'(DEPTH * 4));

        // Reset in the middle of a load discards the partial program.
        do_reset();
        load_word(32'hB000_0001, 1'b0);
        load_word(32'hB000_0002, 1'b0);
        rst = 1'b1;
        step();
        model_clear();
        check("midload_running", 32'(running), 32'd0);
        check("midload_load_ready", 32'(load_ready), 32'd0);
        rst = 1'b0;
        #1;
        load_word(32'hC0DE_0001, 1'b1);
        check("reload_running", 32'(running), 32'd1);
        fetch(32'h0);
        fetch(32'h4);
        // Words offered in RUN are ignored.
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        step();
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch(32'h0);

`ifdef IMEM_WATCHDOG_EN
        do_reset();
        pc = 32'h0;
        load_word(32'h1111_0001, 1'b1);
        check("wd_running", 32'(running), 32'd1);
        for (int i = 1; i < WDOG; i++) step();
        check("wd_still_running", 32'(running), 32'd1);
        check("wd_not_yet", 32'(wdog_expired), 32'd0);
        step();
        check("wd_halted", 32'(halted), 32'd1);
        check("wd_expired", 32'(wdog_expired), 32'd1);
        check("wd_running_off", 32'(running), 32'd0);
        check("wd_instr_valid", 32'(instr_valid), 32'd0);
        check("wd_instr", instr, 32'h0);
        model_clear();
        load_word(32'h2222_0001, 1'b0);
        check("wd_restart_halted", 32'(halted), 32'd0);
        check("wd_restart_flag", 32'(wdog_expired), 32'd0);
        load_word(32'h2222_0002, 1'b1);
        check("wd_rerun", 32'(running), 32'd1);
        fetch(32'h4);
`else
        do_reset();
        pc = 32'h0;
        load_word(32'h1111_0001, 1'b1);
        seen_halt = 1'b0;
        seen_wdog = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            seen_halt |= halted;
            seen_wdog |= wdog_expired;
        end
        check("nowd_halted", 32'(seen_halt), 32'd0);
        check("nowd_expired", 32'(seen_wdog), 32'd0);
        check("nowd_running", 32'(running), 32'd1);
        fetch(32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
